// File: rtl/inst_d_pkg.sv
// Shared types for the decode stage: opcode encodings, decoded control
// bundle and the dest/write-enable tracker entry.
package inst_d_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00,
    OP_ADDI = 6'h01,
    OP_SUB  = 6'h02,
    OP_SUBI = 6'h03,
    OP_MUL  = 6'h04,
    OP_MULI = 6'h05,
    OP_OR   = 6'h06,
    OP_ORI  = 6'h07,
    OP_AND  = 6'h08,
    OP_ANDI = 6'h09,
    OP_XOR  = 6'h0A,
    OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C,
    OP_STW  = 6'h0D,
    OP_BZ   = 6'h0E,
    OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10,
    OP_HALT = 6'h11
  } opcode_e;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_halt;
    logic writes;
    logic dest_is_rt;
    logic reads_rs;
    logic reads_rt;
  } id_ctrl_t;

  typedef struct packed {
    logic [RAW-1:0] dest;
    logic           we;
  } dest_ent_t;

endpackage

// File: rtl/inst_d_decoder.sv
// inst_decoder: purely combinational opcode -> control decode.
// Ports:
//   opcode_i  in  6   instruction opcode field
//   ctrl_o    out     decoded control bundle (all zero for unknown opcodes)
module inst_decoder
  import inst_d_pkg::*;
(
  input  logic [5:0] opcode_i,
  output id_ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_e'(opcode_i))
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        ctrl_o.writes   = 1'b1;
        ctrl_o.reads_rs = 1'b1;
        ctrl_o.reads_rt = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        ctrl_o.writes     = 1'b1;
        ctrl_o.dest_is_rt = 1'b1;
        ctrl_o.reads_rs   = 1'b1;
      end
      OP_LDW: begin
        ctrl_o.is_load    = 1'b1;
        ctrl_o.writes     = 1'b1;
        ctrl_o.dest_is_rt = 1'b1;
        ctrl_o.reads_rs   = 1'b1;
      end
      OP_STW: begin
        ctrl_o.is_store = 1'b1;
        ctrl_o.reads_rs = 1'b1;
        ctrl_o.reads_rt = 1'b1;
      end
      OP_BZ, OP_JR: begin
        ctrl_o.is_branch = 1'b1;
        ctrl_o.reads_rs  = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.is_branch = 1'b1;
        ctrl_o.reads_rs  = 1'b1;
        ctrl_o.reads_rt  = 1'b1;
      end
      OP_HALT: ctrl_o.is_halt = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/inst_d.sv
// inst_d: decode stage. Holds the IF/ID register, decodes it for EX, tracks
// destination/write-enable of the instructions in EX and MEM, and raises
// stall on a read-after-write collision (no forwarding).
// Ports:
//   clk, rst (async, active-low)
//   if_instruction/if_pc        fetch instruction and its PC
//   ex_flush                    squash IF/ID, bubble into EX
//   id_* / rs_f_id..rd_f_id     decode of the IF/ID register
//   ex_dest/mem_dest + reg_write_f_*   hazard tracker feedback
//   stall                       hold IF/ID, bubble into EX
//   halted                      sticky once HALT leaves decode
module inst_d
  import inst_d_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_instruction,
  input  logic [XLEN-1:0] if_pc,
  input  logic            ex_flush,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [5:0]      id_opcode,
  output logic [XLEN-1:0] id_imm,
  output logic [RAW-1:0]  rs_f_id,
  output logic [RAW-1:0]  rt_f_id,
  output logic [RAW-1:0]  rd_f_id,
  output logic [RAW-1:0]  id_dest,
  output logic            reg_write_f_id,
  output logic [RAW-1:0]  ex_dest,
  output logic            reg_write_f_ex,
  output logic [RAW-1:0]  mem_dest,
  output logic            reg_write_f_mem,
  output logic            id_is_load,
  output logic            id_is_store,
  output logic            id_is_branch,
  output logic            stall,
  output logic            halted
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  dest_ent_t       ex_q, ex_d;
  dest_ent_t       mem_q;

  id_ctrl_t        ctrl_raw, ctrl;
  dest_ent_t       id_ent;
  logic            hit_rs, hit_rt, halt_seen;

  inst_decoder u_dec (
    .opcode_i (instr_q[31:26]),
    .ctrl_o   (ctrl_raw)
  );

  // Decode outputs; bubbles hold an all-zero instruction, control is gated anyway.
  always_comb begin
    ctrl           = valid_q ? ctrl_raw : '0;
    id_valid       = valid_q;
    id_pc          = pc_q;
    id_opcode      = valid_q ? instr_q[31:26] : '0;
    id_imm         = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
    rs_f_id        = instr_q[25:21];
    rt_f_id        = instr_q[20:16];
    rd_f_id        = instr_q[15:11];
    id_dest        = ctrl_raw.dest_is_rt ? instr_q[20:16] : instr_q[15:11];
    reg_write_f_id = ctrl.writes & (id_dest != '0);
    id_is_load     = ctrl.is_load;
    id_is_store    = ctrl.is_store;
    id_is_branch   = ctrl.is_branch;
    ex_dest        = ex_q.dest;
    reg_write_f_ex = ex_q.we;
    mem_dest       = mem_q.dest;
    reg_write_f_mem = mem_q.we;
    halted         = halted_q;
    id_ent.dest    = reg_write_f_id ? id_dest : '0;
    id_ent.we      = reg_write_f_id;
  end

  always_comb begin
    hit_rs = ctrl.reads_rs & (rs_f_id != '0) &
             ((ex_q.we & (rs_f_id == ex_q.dest)) | (mem_q.we & (rs_f_id == mem_q.dest)));
    hit_rt = ctrl.reads_rt & (rt_f_id != '0) &
             ((ex_q.we & (rt_f_id == ex_q.dest)) | (mem_q.we & (rt_f_id == mem_q.dest)));
    stall  = valid_q & ~halted_q & (hit_rs | hit_rt);
  end

  // A HALT sitting in IF/ID closes decode on the same edge that sets halted,
  // so the instruction fetched behind it never becomes valid.
  always_comb begin
    halt_seen = ctrl.is_halt;
    halted_d  = halted_q | (halt_seen & ~ex_flush);
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    ex_d      = '0;
    if (ex_flush) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = '0;
    end else if (stall) begin
      ex_d = '0;
    end else if (halted_q | halt_seen) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = '0;
      ex_d    = halted_q ? '0 : id_ent;
    end else begin
      valid_d = 1'b1;
      instr_d = if_instruction;
      pc_d    = if_pc;
      ex_d    = id_ent;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      halted_q <= 1'b0;
      ex_q     <= '0;
      mem_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      ex_q     <= ex_d;
      mem_q    <= ex_q;
    end
  end

endmodule
